core_inst_seq: RTL and testbench
================================

# core_inst_seq

Instruction sequencer that drives the 17-bit `inst` word and the `mem_in` data bus of the Q/K attention core. It replaces the testbench-side instruction generator with a self-contained transmitter. On `start` it streams Q and K vectors into the core's SRAMs, loads the kernel, executes the MAC array, drains the output FIFO into PSUM memory, and then reads PSUM back with a valid strobe. It sits directly above `core` and owns every bit of `inst`.

## Interface
- `col`, 8: MAC array columns; also the number of K vectors per run.
- `bw`, 8: activation/weight width.
- `pr`, 8: parallel lanes per vector; `mem_in` width is `pr*bw`.
- `bw_psum`, 20: psum width (2*bw+4).
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `num_vec`  in  4  number of Q vectors, 1..8; latched on `start`.
- `in_data`  in  pr*bw  Q/K vector stream; Q words first, then K words.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  sequencer accepts `in_data`.
- `fifo_valid`  in  1  core output-FIFO valid.
- `inst`  out  17  core instruction word: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] kernel load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
- `mem_in`  out  pr*bw  data to the core's Q/K SRAMs.
- `rd_valid`  out  1  core `out` bus holds the PSUM row `rd_add`.
- `rd_add`  out  3  PSUM row index qualified by `rd_valid`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- **State sequence:** IDLE → QWR → KWR → KLOAD → EXEC → DRAIN → PWRITE → PREAD → DONE → IDLE.
- **IDLE:**
  - `start`=1 with `num_vec` in 1..8 latches N and enters QWR.
  - `start` with `num_vec`=0 or `num_vec`>8 is ignored.
  - `start` in any other state is ignored.
- **QWR:**
  - `in_ready`=1 while fewer than N words have been accepted.
  - Handshake j (`in_valid`&&`in_ready`) issues `qmem_wr`=1 with qkmem_add=j and `mem_in`=`in_data` in the next cycle.
  - After the N-th handshake, go to KWR.
- **KWR:** same as QWR, but `kmem_wr` for `col` words at addresses 0..col-1. Then go to KLOAD.
- **KLOAD:** `col`+1 cycles.
  - Cycle i < col: `kmem_rd`=1, qkmem_add=i.
  - Cycles 1..col: inst[6]=1.
- **EXEC:** N+1 cycles.
  - Cycle i < N: `qmem_rd`=1, qkmem_add=i.
  - Cycles 1..N: inst[7]=1.
  - inst[6]=0 throughout.
- **DRAIN:** `inst`=0; wait until `fifo_valid`=1.
- **PWRITE:**
  - Each cycle following a cycle with `fifo_valid`=1 issues `ofifo_rd`=1 and `pmem_wr`=1 together, pmem_add=j, for j=0..N-1.
  - If `fifo_valid` was 0, that cycle issues `inst`=0 and j holds.
- **PREAD:**
  - Cycle i < N: `pmem_rd`=1, pmem_add=i.
  - `rd_valid`=1 with `rd_add`=i one cycle later.
  - The phase lasts N+1 cycles.
- **DONE:** `done`=1 for one cycle, `inst`=0, return to IDLE.
- **Unused inst bits:** every inst bit not named for the current cycle is 0. The unused upper address bits [15] and [11] are always 0.

## Timing
- **Reset values:** on `reset`=0 all outputs go to 0 immediately, state goes to IDLE, and counters and N clear. This applies mid-run as well; no partial write completes after reset assertion.
- **Output registers:** `inst`, `mem_in`, `rd_valid`, `rd_add`, `done` and `busy` are registered.
- **Combinational output:** `in_ready` is combinational from state and counter only, never from `in_valid`.
- **Start latency:** `start` sampled at edge k gives `busy`=1 and `in_ready`=1 in cycle k+1.
- **Stalls:** `in_valid`=0 in QWR/KWR produces `inst`=0 for that cycle and holds the counter.
- **Write back-to-back:** back-to-back handshakes give back-to-back write cycles.
- **Run length:** with no stalls and a DRAIN wait of W cycles, the run is N + col + (col+1) + (N+1) + W + N + (N+1) + 1 cycles from QWR entry to IDLE.
- **Phase boundaries:** the last cycle of a phase and the first cycle of the next are adjacent; there are no idle bubbles except in DRAIN.
- **Counter range:** counters are 4 bits and never wrap within a phase; the N=8 and col=8 maxima fit.

## Structure
- **Package `core_inst_pkg`:**
  - state enum;
  - `inst` bit-position constants (OFIFO_RD=16, QK_ADD_HI/LO=15/12, P_ADD_HI/LO=11/8, EXEC=7, KLOAD=6, QRD=5, QWR=4, KRD=3, KWR=2, PRD=1, PWR=0);
  - `INST_W`=17.
- **No sub-module:** single module with one phase counter and one write-index counter; no sub-module is warranted.

## Test plan
- **Single vector:** reset, `start` with N=1, stream 1 Q + 8 K words with `in_valid` always 1 → exactly 1 `qmem_wr` and 8 `kmem_wr` at addresses 0..7, then KLOAD shows inst[6] in 8 cycles, EXEC shows inst[7] in 1 cycle, then `done`.
- **Input stalls:** N=8 with `in_valid` toggling 1,0,1,0 → write cycles only after accepted words, addresses contiguous 0..7, `mem_in` matches the stream order.
- **FIFO stalls:** DRAIN wait W=5, then `fifo_valid` drops for 2 cycles mid-PWRITE → exactly N `ofifo_rd`+`pmem_wr` pairs, pmem_add 0..N-1, 2-cycle `inst`=0 gap.
- **Readback:** N=4, PREAD → `pmem_rd` at 0..3, `rd_valid` asserted one cycle later each with `rd_add` 0..3, `done` one cycle after the last `rd_valid`.
- **Illegal start:** `start` with `num_vec`=0, and `start` asserted during EXEC → no state change, no extra run.
- **Reset mid-run:** `reset`=0 during KWR → all outputs 0 within the same cycle, IDLE; a subsequent `start` with N=2 completes normally.

Source files
------------

// File: rtl/core_inst_pkg.sv
// Shared definitions for the Q/K attention core instruction sequencer:
// phase encoding and bit positions within the 17-bit core instruction word.
package core_inst_pkg;

   localparam int INST_W = 17;

   localparam int OFIFO_RD  = 16;
   localparam int QK_ADD_HI = 15;
   localparam int QK_ADD_LO = 12;
   localparam int P_ADD_HI  = 11;
   localparam int P_ADD_LO  = 8;
   localparam int EXEC      = 7;
   localparam int KLOAD     = 6;
   localparam int QRD       = 5;
   localparam int QWR       = 4;
   localparam int KRD       = 3;
   localparam int KWR       = 2;
   localparam int PRD       = 1;
   localparam int PWR       = 0;

   typedef enum logic [3:0] {
      StIdle,
      StQwr,
      StKwr,
      StKload,
      StExec,
      StDrain,
      StPwrite,
      StPread,
      StDone
   } state_e;

endpackage

// File: rtl/core_inst_seq.sv
// Instruction sequencer for the Q/K attention core: streams Q/K vectors into the core
// SRAMs, loads the kernel, executes, drains the output FIFO to PSUM and reads it back.
module core_inst_seq
   import core_inst_pkg::*;
#(
   parameter int unsigned col     = 8,
   parameter int unsigned bw      = 8,
   parameter int unsigned pr      = 8,
   parameter int unsigned bw_psum = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           num_vec,
   input  logic [pr*bw-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 fifo_valid,
   output logic [INST_W-1:0]    inst,
   output logic [pr*bw-1:0]     mem_in,
   output logic                 rd_valid,
   output logic [2:0]           rd_add,
   output logic                 busy,
   output logic                 done
);

   if (col == 0 || col > 8 || bw_psum != 2 * bw + 4) begin : g_param_check
      $error("core_inst_seq: unsupported parameter set");
   end

   localparam logic [3:0] ColCnt = 4'(col);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;    // phase cycle counter (KLOAD/EXEC/PREAD)
   logic [3:0]          widx_q, widx_d;  // write index (QWR/KWR/PWRITE)
   logic [3:0]          n_q, n_d;
   logic [INST_W-1:0]   inst_d;
   logic [pr*bw-1:0]    mem_in_d;
   logic                done_d;
   logic                hs;
   logic [3:0]          last;

   // in_ready depends only on phase and write index, never on in_valid.
   always_comb begin
      in_ready = 1'b0;
      if (state_q == StQwr) begin
         in_ready = (widx_q < n_q);
      end else if (state_q == StKwr) begin
         in_ready = (widx_q < ColCnt);
      end
   end

   assign hs = in_valid & in_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      widx_d   = widx_q;
      n_d      = n_q;
      inst_d   = '0;
      mem_in_d = '0;
      done_d   = 1'b0;
      last     = (state_q == StQwr) ? n_q - 4'd1 : ColCnt - 4'd1;
      unique case (state_q)
         StIdle: begin
            if (start && num_vec != 4'd0 && num_vec <= 4'd8) begin
               n_d     = num_vec;
               cnt_d   = '0;
               widx_d  = '0;
               state_d = StQwr;
            end
         end
         StQwr, StKwr: begin
            if (hs) begin
               if (state_q == StQwr) begin
                  inst_d[QWR] = 1'b1;
               end else begin
                  inst_d[KWR] = 1'b1;
               end
               inst_d[QK_ADD_HI-1:QK_ADD_LO] = widx_q[2:0];
               mem_in_d = in_data;
               if (widx_q == last) begin
                  widx_d  = '0;
                  state_d = (state_q == StQwr) ? StKwr : StKload;
               end else begin
                  widx_d = widx_q + 4'd1;
               end
            end
         end
         StKload: begin
            // SRAM read data lags the address by a cycle, so kernel load trails kmem_rd.
            if (cnt_q < ColCnt) begin
               inst_d[KRD] = 1'b1;
               inst_d[QK_ADD_HI-1:QK_ADD_LO] = cnt_q[2:0];
            end
            inst_d[KLOAD] = (cnt_q != 4'd0);
            if (cnt_q == ColCnt) begin
               cnt_d   = '0;
               state_d = StExec;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StExec: begin
            if (cnt_q < n_q) begin
               inst_d[QRD] = 1'b1;
               inst_d[QK_ADD_HI-1:QK_ADD_LO] = cnt_q[2:0];
            end
            inst_d[EXEC] = (cnt_q != 4'd0);
            if (cnt_q == n_q) begin
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StDrain: begin
            if (fifo_valid) begin
               widx_d  = '0;
               state_d = StPwrite;
            end
         end
         StPwrite: begin
            if (fifo_valid) begin
               inst_d[OFIFO_RD] = 1'b1;
               inst_d[PWR]      = 1'b1;
               inst_d[P_ADD_HI-1:P_ADD_LO] = widx_q[2:0];
               if (widx_q == n_q - 4'd1) begin
                  widx_d  = '0;
                  cnt_d   = '0;
                  state_d = StPread;
               end else begin
                  widx_d = widx_q + 4'd1;
               end
            end
         end
         StPread: begin
            if (cnt_q < n_q) begin
               inst_d[PRD] = 1'b1;
               inst_d[P_ADD_HI-1:P_ADD_LO] = cnt_q[2:0];
            end
            if (cnt_q == n_q) begin
               cnt_d   = '0;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         widx_q   <= '0;
         n_q      <= '0;
         inst     <= '0;
         mem_in   <= '0;
         rd_valid <= 1'b0;
         rd_add   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         widx_q   <= widx_d;
         n_q      <= n_d;
         inst     <= inst_d;
         mem_in   <= mem_in_d;
         // The core's out bus holds the PSUM row one cycle after pmem_rd.
         rd_valid <= inst[PRD];
         rd_add   <= inst[PRD] ? inst[P_ADD_HI-1:P_ADD_LO] : 3'd0;
         busy     <= (state_d != StIdle);
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_core_inst_seq.sv
// Randomized bench for core_inst_seq: builds the expected per-cycle output timeline of
// each run from the phase rules and compares it with what the sequencer produces.
module tb_core_inst_seq;
   import core_inst_pkg::*;

   localparam int unsigned COL = 8;
   localparam int unsigned BW  = 8;
   localparam int unsigned PR  = 8;
   localparam int unsigned BWP = 20;
   localparam int DW = PR * BW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    num_vec = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          fifo_valid = 1'b0;
   logic [16:0]   inst;
   logic [DW-1:0] mem_in;
   logic          rd_valid;
   logic [2:0]    rd_add;
   logic          busy;
   logic          done;

   core_inst_seq #(
      .col     (COL),
      .bw      (BW),
      .pr      (PR),
      .bw_psum (BWP)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .num_vec    (num_vec),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .fifo_valid (fifo_valid),
      .inst       (inst),
      .mem_in     (mem_in),
      .rd_valid   (rd_valid),
      .rd_add     (rd_add),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [16:0] fld(input int b);
      return 17'(1) << b;
   endfunction

   function automatic logic [16:0] qk(input int a);
      return 17'(a) << QK_ADD_LO;
   endfunction

   function automatic logic [16:0] pa(input int a);
      return 17'(a) << P_ADD_LO;
   endfunction

   // Output trace, one entry per cycle sampled on the falling edge.
   logic          rec = 1'b0;
   logic [16:0]   o_inst[$];
   logic [DW-1:0] o_mem[$];
   logic          o_rv[$];
   logic [2:0]    o_ra[$];
   logic          o_busy[$];
   logic          o_done[$];
   logic          o_rdy[$];

   always @(negedge clk) begin
      if (rec) begin
         o_inst.push_back(inst);
         o_mem.push_back(mem_in);
         o_rv.push_back(rd_valid);
         o_ra.push_back(rd_add);
         o_busy.push_back(busy);
         o_done.push_back(done);
         o_rdy.push_back(in_ready);
      end
   end

   // mode: 0 in_valid always 1, 1 toggling 1,0,..., 2 random.
   // dz: zero-fifo_valid DRAIN cycles before the exit cycle; gap_len: fifo_valid drop in PWRITE.
   task automatic run(input int n, input int mode, input int dz, input int gap_len,
                      input bit poke);
      logic [16:0]   e_inst[$];
      logic [DW-1:0] e_mem[$];
      bit            e_wr[$];
      logic [DW-1:0] words[$];
      logic [16:0]   w;
      int idx, tog, s_len, gap_at, gap_left, pc, len;
      bit rv;
      for (int i = 0; i < n + int'(COL); i++) words.push_back({$urandom, $urandom});
      o_inst.delete(); o_mem.delete(); o_rv.delete(); o_ra.delete();
      o_busy.delete(); o_done.delete(); o_rdy.delete();

      @(posedge clk); #1;
      start = 1'b1;
      num_vec = 4'(n);
      @(posedge clk); #1;
      start = 1'b0;
      rec = 1'b1;
      e_inst.push_back('0); e_mem.push_back('0); e_wr.push_back(1'b0);

      idx = 0; tog = 0; s_len = 0;
      while (idx < n + int'(COL)) begin
         num_vec = 4'($urandom);
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (tog == 0);
            default: in_valid = ($urandom_range(0, 2) != 0);
         endcase
         tog ^= 1;
         in_data = {$urandom, $urandom};
         s_len++;
         if (in_valid) begin
            in_data = words[idx];
            w = (idx < n) ? (fld(QWR) | qk(idx)) : (fld(KWR) | qk(idx - n));
            e_inst.push_back(w); e_mem.push_back(words[idx]); e_wr.push_back(1'b1);
            idx++;
         end else begin
            e_inst.push_back('0); e_mem.push_back('0); e_wr.push_back(1'b0);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;

      for (int i = 0; i <= int'(COL); i++) begin
         w = '0;
         if (i < int'(COL)) w = fld(KRD) | qk(i);
         if (i > 0) w |= fld(KLOAD);
         e_inst.push_back(w);
      end
      for (int i = 0; i <= n; i++) begin
         w = '0;
         if (i < n) w = fld(QRD) | qk(i);
         if (i > 0) w |= fld(EXEC);
         e_inst.push_back(w);
      end
      for (int i = 0; i <= dz; i++) e_inst.push_back('0);

      for (int c = 0; c < int'(COL) + 1 + n + 1 + dz; c++) begin
         start = poke && (c == int'(COL) + 2);
         num_vec = 4'd2;
         fifo_valid = 1'b0;
         @(posedge clk); #1;
      end
      start = 1'b0;
      fifo_valid = 1'b1;
      @(posedge clk); #1;

      gap_at = $urandom_range(0, n - 1);
      gap_left = gap_len;
      pc = 0;
      while (pc < n) begin
         fifo_valid = !(pc == gap_at && gap_left > 0);
         if (fifo_valid) begin
            e_inst.push_back(fld(OFIFO_RD) | fld(PWR) | pa(pc));
            pc++;
         end else begin
            e_inst.push_back('0);
            gap_left--;
         end
         @(posedge clk); #1;
      end
      fifo_valid = 1'b0;

      for (int i = 0; i <= n; i++) e_inst.push_back((i < n) ? (fld(PRD) | pa(i)) : 17'd0);
      e_inst.push_back('0);
      len = e_inst.size() - 1;
      for (int i = 0; i < 3; i++) e_inst.push_back('0);

      for (int g = 0; g < 400 && o_inst.size() < e_inst.size(); g++) @(posedge clk);
      rec = 1'b0;
      check("trace_len", 64'(o_inst.size()), 64'(e_inst.size()));
      if (o_inst.size() < e_inst.size()) return;

      for (int t = 0; t < e_inst.size(); t++) begin
         check("inst", o_inst[t], e_inst[t]);
         check("busy", o_busy[t], t < len);
         check("done", o_done[t], t == len);
         check("in_ready", o_rdy[t], t < s_len);
         if (t < e_wr.size() && e_wr[t]) check("mem_in", o_mem[t], e_mem[t]);
         rv = (t > 0) && e_inst[t-1][PRD];
         check("rd_valid", o_rv[t], rv);
         if (rv) check("rd_add", o_ra[t], e_inst[t-1][P_ADD_HI-1:P_ADD_LO]);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_inst"}, inst, '0);
      check({tag, "_mem_in"}, mem_in, '0);
      check({tag, "_rd_valid"}, rd_valid, '0);
      check({tag, "_rd_add"}, rd_add, '0);
      check({tag, "_busy"}, busy, '0);
      check({tag, "_done"}, done, '0);
      check({tag, "_in_ready"}, in_ready, '0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b1;

      run(1, 0, 0, 0, 1'b0);
      run(8, 1, 2, 0, 1'b0);
      run(3, 2, 4, 2, 1'b0);
      run(4, 0, 1, 0, 1'b0);

      // Illegal starts in IDLE must not begin a run.
      @(posedge clk); #1;
      start = 1'b1; num_vec = 4'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("illegal0_busy", busy, 1'b0);
      check("illegal0_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      start = 1'b1; num_vec = 4'($urandom_range(9, 15));
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("illegal9_busy", busy, 1'b0);
      check("illegal9_in_ready", in_ready, 1'b0);

      run(5, 2, 3, 1, 1'b1);

      // Reset asserted mid-KWR with a handshake pending.
      @(posedge clk); #1;
      start = 1'b1; num_vec = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      check("midrun_busy", busy, 1'b1);
      check("midrun_in_ready", in_ready, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      @(posedge clk); #1;
      check("reset_hold_inst", inst, '0);
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check_idle_outputs("after_reset");

      run(2, 0, 1, 0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         run($urandom_range(1, 8), 2, $urandom_range(0, 5), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
